mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width to data memory.
REQ-002 SHALL have parameter BASE_ADDR, default 32'd1024: byte address mapped to word 0.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16: maximum cycles spent waiting for mem_ack.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst, input, 1: synchronous reset.
REQ-007 SHALL have port MEM_R_EN, input, 1: load request from the pipeline.
REQ-008 SHALL have port MEM_W_EN, input, 1: store request from the pipeline.
REQ-009 SHALL have port ALU_res, input, 32: byte address from the execute stage result.
REQ-010 SHALL have port ST_value, input, 32: forwarded store data.
REQ-011 SHALL have port mem_rdata, input, 32: memory read data, valid when mem_ack=1.
REQ-012 SHALL have port mem_ack, input, 1: memory completion strobe.
REQ-013 SHALL have ports mem_req (1), mem_we (1), mem_addr (ADDR_W) and mem_wdata (32) as outputs: memory request bus.
REQ-014 SHALL have port dataMem_out, output, 32: load result presented to writeback.
REQ-015 SHALL have port mem_stall, output, 1: freezes all upstream stages.
REQ-016 SHALL have ports mem_err and misalign, outputs, 1 each: one-cycle error pulses.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-018 SHALL, in IDLE with MEM_R_EN or MEM_W_EN high, capture the address, data and we in one cycle, enter ACCESS next cycle and assert mem_req from that cycle.
REQ-019 SHALL set mem_addr = ((ALU_res - BASE_ADDR) >> 2) truncated to ADDR_W bits.
REQ-020 SHALL give MEM_W_EN precedence when both enables are high: a store is performed and the read is ignored.
REQ-021 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable throughout ACCESS.
REQ-022 SHALL, on mem_ack in ACCESS, drop mem_req the next cycle, enter DONE, and register mem_rdata into dataMem_out for loads (dataMem_out is unchanged for stores).
REQ-023 SHALL drive mem_stall combinationally high in IDLE while an enable is high, high throughout ACCESS, and low in DONE.
REQ-024 SHALL return from DONE to IDLE unconditionally after one cycle; enables seen in DONE are ignored.
REQ-025 SHALL count ACCESS cycles from 1; if ACK_TIMEOUT is reached without an ack, it SHALL enter DONE, pulse mem_err for one cycle and set dataMem_out=0.
REQ-026 SHALL treat an ack arriving in the same cycle the count reaches ACK_TIMEOUT as a success (no mem_err).
REQ-027 SHALL ignore mem_ack outside ACCESS.
REQ-028 SHALL give a load latency from request cycle t with ack at t+k to valid data of k+1 cycles; the minimum is 2 (ack at t+1).

Reset
REQ-029 SHALL, with rst high at a clock edge, force IDLE and set mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dataMem_out=0, mem_err=0, misalign=0 and counter=0.
REQ-030 SHALL let rst abort an in-flight ACCESS with no DONE cycle and no error pulse.
REQ-031 SHALL drive mem_stall=0 while rst is high.

Configuration
REQ-032 SHALL, with MEM_MISALIGN_CHECK_EN defined, handle an enable with ALU_res[1:0]!=0 in IDLE by skipping ACCESS, going to DONE, pulsing misalign for one cycle and setting dataMem_out=0.
REQ-033 SHALL, without MEM_MISALIGN_CHECK_EN, ignore ALU_res[1:0] and tie misalign to 0.

Structure
REQ-034 SHALL place the state encodings, the default BASE_ADDR and the default ACK_TIMEOUT in the shared defines.v.
REQ-035 SHALL implement the ACK_TIMEOUT counter as sub-module mem_ack_timer (clear, enable, expired outputs).

Verification
REQ-036 SHALL cover a load: ALU_res=1032, MEM_R_EN=1, ack at 3rd ACCESS cycle with rdata=0xDEADBEEF -> mem_addr=2, mem_stall high for 4 cycles, dataMem_out=0xDEADBEEF in DONE.
REQ-037 SHALL cover a store with both enables high: ALU_res=1024, ST_value=0x12345678 -> mem_we=1, mem_addr=0, mem_wdata=0x12345678, dataMem_out unchanged.
REQ-038 SHALL cover a timeout: load with no ack and ACK_TIMEOUT=16 -> mem_err pulses once after 16 ACCESS cycles, dataMem_out=0, mem_stall then drops.
REQ-039 SHALL cover a reset abort: rst on the 2nd ACCESS cycle -> next cycle mem_req=0, IDLE, no mem_err; a late ack is ignored.
REQ-040 SHALL cover misalignment with MEM_MISALIGN_CHECK_EN: ALU_res=1026 load -> mem_req never rises, misalign pulses once, dataMem_out=0; without the macro -> mem_addr=0 and a normal access.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and defaults for the memory-stage controller: FSM encoding,
// default memory window base and ack timeout, and address helper.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_ACK_TIMEOUT = 16;

    function automatic logic [31:0] byte_offset(input logic [31:0] byte_addr,
                                                input logic [31:0] base_addr);
        return byte_addr - base_addr;
    endfunction

endpackage

// File: rtl/mem_ack_timer.sv
// Counts ACCESS cycles and flags the cycle in which the ack timeout is reached.
module mem_ack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    // Cycle counter: zero in the first counted cycle, so cycle n holds n-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns pipeline load/store enables into a held
// request on the data-memory bus, with ack timeout and pipeline stall.
// Optional macro MEM_MISALIGN_CHECK_EN rejects non-word-aligned addresses.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_res,
    input  logic [31:0]       ST_value,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       dataMem_out,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              misalign
);

    mem_state_e        state_r;
    mem_state_e        next_state_s;
    logic              req_s;
    logic              capture_s;
    logic              req_clr_s;
    logic              load_ack_s;
    logic              err_set_s;
    logic              mis_set_s;
    logic              zero_data_s;
    logic              stall_s;
    logic              expired_s;
    logic [31:0]       byte_off_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic              unused_bits_s;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [31:0]       data_out_r;
    logic              mem_err_r;
    logic              misalign_r;

    assign req_s         = MEM_R_EN || MEM_W_EN;
    assign byte_off_s    = byte_offset(ALU_res, BASE_ADDR);
    assign word_addr_s   = byte_off_s[ADDR_W+1:2];
    assign unused_bits_s = ^{byte_off_s[31:ADDR_W+2], byte_off_s[1:0]};

    mem_ack_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_r != ST_ACCESS),
        .enable  (state_r == ST_ACCESS),
        .expired (expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode plus one-cycle control strobes for the datapath.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        req_clr_s    = 1'b0;
        load_ack_s   = 1'b0;
        err_set_s    = 1'b0;
        mis_set_s    = 1'b0;
        zero_data_s  = 1'b0;
        stall_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    stall_s = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
                    if (ALU_res[1:0] != 2'b00) begin
                        next_state_s = ST_DONE;
                        mis_set_s    = 1'b1;
                        zero_data_s  = 1'b1;
                    end else begin
                        next_state_s = ST_ACCESS;
                        capture_s    = 1'b1;
                    end
`else
                    next_state_s = ST_ACCESS;
                    capture_s    = 1'b1;
`endif
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                stall_s = 1'b1;
                // An ack in the expiry cycle still counts as success.
                if (mem_ack) begin
                    next_state_s = ST_DONE;
                    req_clr_s    = 1'b1;
                    load_ack_s   = !mem_we_r;
                end else if (expired_s) begin
                    next_state_s = ST_DONE;
                    req_clr_s    = 1'b1;
                    err_set_s    = 1'b1;
                    zero_data_s  = 1'b1;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Request bus, load result and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
            data_out_r  <= 32'd0;
            mem_err_r   <= 1'b0;
            misalign_r  <= 1'b0;
        end else begin
            mem_err_r  <= err_set_s;
            misalign_r <= mis_set_s;
            if (capture_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= MEM_W_EN;
                mem_addr_r  <= word_addr_s;
                mem_wdata_r <= ST_value;
            end else if (req_clr_s) begin
                mem_req_r <= 1'b0;
            end else begin
                mem_req_r <= mem_req_r;
            end
            if (load_ack_s) begin
                data_out_r <= mem_rdata;
            end else if (zero_data_s) begin
                data_out_r <= 32'd0;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign dataMem_out = data_out_r;
    assign mem_err     = mem_err_r;
    assign misalign    = misalign_r;
    assign mem_stall   = stall_s && !rst;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl: load, store, timeout,
// ack-at-expiry, reset abort and misalignment handling.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_res;
    logic [31:0] ST_value;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] dataMem_out;
    logic        mem_stall;
    logic        mem_err;
    logic        misalign;

    int n_checks;
    int n_fails;

    mem_stage_ctrl #(
        .ADDR_W      (10),
        .BASE_ADDR   (32'd1024),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .ALU_res     (ALU_res),
        .ST_value    (ST_value),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .dataMem_out (dataMem_out),
        .mem_stall   (mem_stall),
        .mem_err     (mem_err),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        MEM_R_EN  = 1'b0;
        MEM_W_EN  = 1'b0;
        ALU_res   = 32'd0;
        ST_value  = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;

        // Reset state, with an enable high to show stall is held low in reset.
        tick();
        tick();
        MEM_R_EN = 1'b1;
        #1;
        check_eq("rst_stall", mem_stall, 32'd0);
        check_eq("rst_req", mem_req, 32'd0);
        check_eq("rst_data", dataMem_out, 32'd0);
        check_eq("rst_err", mem_err, 32'd0);
        MEM_R_EN = 1'b0;
        rst = 1'b0;
        tick();

        // Stray ack in IDLE is ignored.
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        check_eq("idle_ack_req", mem_req, 32'd0);
        check_eq("idle_ack_data", dataMem_out, 32'd0);

        // Load at 1032 -> word 2, ack on third ACCESS cycle.
        MEM_R_EN = 1'b1; ALU_res = 32'd1032;
        #1;
        check_eq("ld_stall_idle", mem_stall, 32'd1);
        tick();
        MEM_R_EN = 1'b0;
        check_eq("ld_req_a1", mem_req, 32'd1);
        check_eq("ld_addr", mem_addr, 32'd2);
        check_eq("ld_we", mem_we, 32'd0);
        check_eq("ld_stall_a1", mem_stall, 32'd1);
        tick();
        check_eq("ld_stall_a2", mem_stall, 32'd1);
        check_eq("ld_req_a2", mem_req, 32'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("ld_stall_a3", mem_stall, 32'd1);
        tick();
        mem_ack = 1'b0;
        check_eq("ld_done_req", mem_req, 32'd0);
        check_eq("ld_done_data", dataMem_out, 32'hDEAD_BEEF);
        check_eq("ld_done_stall", mem_stall, 32'd0);
        check_eq("ld_done_err", mem_err, 32'd0);
        tick();
        check_eq("ld_idle_stall", mem_stall, 32'd0);

        // Store with both enables high, minimum-latency ack.
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; ALU_res = 32'd1024; ST_value = 32'h1234_5678;
        tick();
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        check_eq("st_we", mem_we, 32'd1);
        check_eq("st_addr", mem_addr, 32'd0);
        check_eq("st_wdata", mem_wdata, 32'h1234_5678);
        check_eq("st_req", mem_req, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        check_eq("st_done_data", dataMem_out, 32'hDEAD_BEEF);
        check_eq("st_done_req", mem_req, 32'd0);
        tick();

        // Load at 1100 -> word 19 with no ack: timeout after 16 ACCESS cycles.
        MEM_R_EN = 1'b1; ALU_res = 32'd1100;
        tick();
        MEM_R_EN = 1'b0;
        check_eq("to_addr", mem_addr, 32'd19);
        for (int i = 1; i <= 16; i++) begin
            check_eq($sformatf("to_req_c%0d", i), mem_req, 32'd1);
            check_eq($sformatf("to_err_c%0d", i), mem_err, 32'd0);
            tick();
        end
        check_eq("to_err_pulse", mem_err, 32'd1);
        check_eq("to_data_zero", dataMem_out, 32'd0);
        check_eq("to_stall", mem_stall, 32'd0);
        check_eq("to_req_drop", mem_req, 32'd0);
        tick();
        check_eq("to_err_once", mem_err, 32'd0);

        // Ack arriving on the 16th ACCESS cycle is a success.
        MEM_R_EN = 1'b1; ALU_res = 32'd1028;
        tick();
        MEM_R_EN = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        check_eq("edge_req_c16", mem_req, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check_eq("edge_err", mem_err, 32'd0);
        check_eq("edge_data", dataMem_out, 32'hCAFE_F00D);
        tick();

        // Reset on the second ACCESS cycle aborts the access.
        MEM_R_EN = 1'b1; ALU_res = 32'd1040;
        tick();
        MEM_R_EN = 1'b0;
        check_eq("ab_addr", mem_addr, 32'd4);
        tick();
        rst = 1'b1;
        #1;
        check_eq("ab_stall_rst", mem_stall, 32'd0);
        tick();
        rst = 1'b0;
        check_eq("ab_req", mem_req, 32'd0);
        check_eq("ab_err", mem_err, 32'd0);
        check_eq("ab_addr_clr", mem_addr, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        check_eq("ab_late_err", mem_err, 32'd0);
        check_eq("ab_late_data", dataMem_out, 32'd0);
        check_eq("ab_late_stall", mem_stall, 32'd0);
        check_eq("ab_late_req", mem_req, 32'd0);

        // Misaligned load at 1026.
        MEM_R_EN = 1'b1; ALU_res = 32'd1026;
        tick();
        MEM_R_EN = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        check_eq("mis_req", mem_req, 32'd0);
        check_eq("mis_pulse", misalign, 32'd1);
        check_eq("mis_data", dataMem_out, 32'd0);
        tick();
        check_eq("mis_once", misalign, 32'd0);
        check_eq("mis_req_idle", mem_req, 32'd0);
`else
        check_eq("mis_req", mem_req, 32'd1);
        check_eq("mis_addr", mem_addr, 32'd0);
        check_eq("mis_flag", misalign, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        tick();
        mem_ack = 1'b0;
        check_eq("mis_data", dataMem_out, 32'h0BAD_CAFE);
        check_eq("mis_flag_done", misalign, 32'd0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
